overflow_flag_decoder: RTL and testbench
========================================

Name: overflow_flag_decoder

Overview:
- Receiving end of the overflow-marked 128-bit AXI stream.
- Upstream sets DATA bit FLAG_BIT on the first beat after one or more beats were dropped under backpressure.
- This block accepts the stream through a 2-entry skid buffer and forwards it with the flag bit cleared. It also keeps statistics: flagged beats, total beats, a sticky overflow indicator, and the beat index of the first flagged beat.
- Sits between the trace stream and the capture DMA / host-readable status registers.

Parameters:
DATA_WIDTH, 128, stream data width
FLAG_BIT, 31, bit position of the overflow flag within tdata (must be < DATA_WIDTH)
CNT_WIDTH, 32, width of all statistics counters

Ports:
aclk  input  1  clock; all logic rising-edge
areset  input  1  synchronous, active-high reset
input_axis_tvalid  input  1  upstream beat valid
input_axis_tready  output  1  upstream ready
input_axis_tdata  input  DATA_WIDTH  upstream beat; bit FLAG_BIT = overflow flag
output_axis_tvalid  output  1  downstream beat valid
output_axis_tready  input  1  downstream ready
output_axis_tdata  output  DATA_WIDTH  forwarded beat, bit FLAG_BIT forced 0
clear_stats  input  1  single-cycle pulse; clears all statistics
overflow_sticky  output  1  set on any flagged beat accepted since reset/clear
overflow_count  output  CNT_WIDTH  number of flagged beats accepted, saturating
beat_count  output  CNT_WIDTH  number of beats accepted, saturating
first_overflow_index  output  CNT_WIDTH  beat_count value at the first flagged beat (0-based)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (aclk, areset). All state is updated only on the rising edge of aclk.
- Reset values:
  - input_axis_tready=1, output_axis_tvalid=0, output_axis_tdata=0.
  - overflow_sticky=0, overflow_count=0, beat_count=0, first_overflow_index=0.
  - Buffer occupancy=0.
- Accept and pop:
  - Accept = input_axis_tvalid & input_axis_tready.
  - Pop = output_axis_tvalid & output_axis_tready.
- Skid buffer:
  - Occupancy 0..2, FIFO order preserved.
  - input_axis_tready is registered and equals (next occupancy < 2). It must not depend combinationally on output_axis_tready.
  - output_axis_tvalid = (occupancy > 0). output_axis_tdata = head entry.
  - Simultaneous accept and pop: occupancy unchanged, data order preserved.
  - Accept while full cannot occur (tready=0). Pop while empty cannot occur.
- Latency: a beat accepted in cycle N is presented in cycle N+1 at the earliest. Throughput is 1 beat/cycle while the downstream is ready every cycle.
- Data transform: stored beat = input_axis_tdata with bit FLAG_BIT cleared. All other bits pass unchanged.
- Statistics update on accept only. Flagged = input_axis_tdata[FLAG_BIT]=1.
  - beat_count += 1, saturating at all-ones.
  - If flagged: overflow_count += 1 (saturating) and overflow_sticky <= 1.
  - If flagged and overflow_sticky=0: first_overflow_index <= beat_count (pre-increment value).
  - Data beats are never dropped because of saturation; only the counters stop.
- clear_stats:
  - Zeroes beat_count, overflow_count, overflow_sticky and first_overflow_index.
  - Does not touch buffer contents or the handshake.
  - Same cycle as an accept: clear applies first, then the accept. Result: beat_count=1; if that beat is flagged, overflow_count=1, sticky=1, first_overflow_index=0.
- Reset mid-operation: buffer contents are discarded (occupancy 0). The partially delivered beat is lost; the downstream sees tvalid drop on the next cycle. Statistics are zeroed.
- A tvalid with tready=0 on the input side is not an accept and updates nothing.

Test Plan:
1. Streaming: reset, output_tready=1, send 4 beats with data=i*0x1_0000_0001, flag clear. Required: outputs appear one cycle later in order, identical data; beat_count=4; overflow_count=0; sticky=0.
2. Flag strip: send beat 0xFFFF...FFFF (bit 31 set) as the 3rd beat. Required: output data 0xFFFF...7FFF_FFFF; overflow_count=1; sticky=1; first_overflow_index=2.
3. Backpressure: hold output_tready=0 and offer 5 beats. Required: exactly 2 accepted, and input_tready=0 the cycle after the 2nd accept. Release tready: both beats emerge in order, then the remaining 3 follow with no loss or duplication.
4. Simultaneous clear: assert clear_stats in the same cycle a flagged beat is accepted, after 10 prior beats. Required next cycle: beat_count=1, overflow_count=1, first_overflow_index=0.
5. Saturation: with CNT_WIDTH=4, accept 20 flagged beats. Required: beat_count=15, overflow_count=15, and data still forwarded for all 20 beats.
6. Mid-operation reset: buffer full (2 beats), assert areset for 1 cycle. Required: output_tvalid=0, input_tready=1, and all statistics=0 on the following cycle.

Source files
------------

// File: rtl/overflow_flag_decoder.sv
// overflow_flag_decoder: receives the overflow-marked AXI stream through a
// 2-entry skid buffer, strips the overflow flag bit from each forwarded beat
// and keeps saturating statistics about accepted and flagged beats.
module overflow_flag_decoder #(
    parameter int DATA_WIDTH = 128,
    parameter int FLAG_BIT   = 31,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    input  logic                  clear_stats,
    output logic                  overflow_sticky,
    output logic [CNT_WIDTH-1:0]  overflow_count,
    output logic [CNT_WIDTH-1:0]  beat_count,
    output logic [CNT_WIDTH-1:0]  first_overflow_index
);

    localparam logic [DATA_WIDTH-1:0] FLAG_MASK =
        {{(DATA_WIDTH-1){1'b0}}, 1'b1} << FLAG_BIT;

    logic [1:0]            occ;
    logic [1:0]            occ_next;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;
    logic                  ready;
    logic                  accept;
    logic                  pop;
    logic                  flagged;
    logic [DATA_WIDTH-1:0] stripped;

    logic [CNT_WIDTH-1:0]  beat_base;
    logic [CNT_WIDTH-1:0]  ovf_base;
    logic [CNT_WIDTH-1:0]  first_base;
    logic                  sticky_base;

    // Counter increment that holds at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign input_axis_tready  = ready;
    assign output_axis_tvalid = (occ != 2'd0);
    assign output_axis_tdata  = head;

    assign accept   = input_axis_tvalid & ready;
    assign pop      = output_axis_tvalid & output_axis_tready;
    assign flagged  = input_axis_tdata[FLAG_BIT];
    assign stripped = input_axis_tdata & ~FLAG_MASK;

    // Next buffer occupancy from the accept/pop pair; both together leave it unchanged.
    always_comb begin
        occ_next = occ;
        case ({accept, pop})
            2'b10:   occ_next = occ + 2'd1;
            2'b01:   occ_next = occ - 2'd1;
            default: occ_next = occ;
        endcase
    end

    // Statistics as seen after an optional clear, so a clear and an accept in the same cycle compose.
    always_comb begin
        beat_base   = clear_stats ? '0   : beat_count;
        ovf_base    = clear_stats ? '0   : overflow_count;
        first_base  = clear_stats ? '0   : first_overflow_index;
        sticky_base = clear_stats ? 1'b0 : overflow_sticky;
    end

    // Occupancy, registered ready and the head entry that drives the output.
    always_ff @(posedge aclk) begin
        if (areset) begin
            occ   <= 2'd0;
            ready <= 1'b1;
            head  <= '0;
        end else begin
            occ   <= occ_next;
            ready <= (occ_next < 2'd2);
            if (pop) begin
                if (occ == 2'd2) begin
                    head <= tail;
                end else if (accept) begin
                    head <= stripped;
                end
            end else if (accept && (occ == 2'd0)) begin
                head <= stripped;
            end
        end
    end

    // Second entry: only written when a beat lands behind a head that stays put.
    always_ff @(posedge aclk) begin
        if (accept && (occ == 2'd1) && !pop) begin
            tail <= stripped;
        end
    end

    // Beat and overflow statistics, updated only on an accepted beat or a clear.
    always_ff @(posedge aclk) begin
        if (areset) begin
            beat_count           <= '0;
            overflow_count       <= '0;
            first_overflow_index <= '0;
            overflow_sticky      <= 1'b0;
        end else begin
            beat_count           <= beat_base;
            overflow_count       <= ovf_base;
            first_overflow_index <= first_base;
            overflow_sticky      <= sticky_base;
            if (accept) begin
                beat_count <= sat_inc(beat_base);
                if (flagged) begin
                    overflow_count  <= sat_inc(ovf_base);
                    overflow_sticky <= 1'b1;
                    if (!sticky_base) begin
                        first_overflow_index <= beat_base;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_overflow_flag_decoder.sv
// Bench for overflow_flag_decoder: a queue-based model plus directed vectors.
// Two instances share the stimulus: full-width counters and 4-bit counters.
module tb_overflow_flag_decoder;

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic         in_valid = 1'b0;
    logic [127:0] in_data = '0;
    logic         out_ready = 1'b0;
    logic         clear = 1'b0;

    logic         a_tready, a_tvalid, a_sticky;
    logic [127:0] a_tdata;
    logic [31:0]  a_oc, a_bc, a_first;
    logic         b_tready, b_tvalid, b_sticky;
    logic [127:0] b_tdata;
    logic [3:0]   b_oc, b_bc, b_first;

    overflow_flag_decoder #(.DATA_WIDTH(128), .FLAG_BIT(31), .CNT_WIDTH(32)) dut_a (
        .aclk(aclk), .areset(areset),
        .input_axis_tvalid(in_valid), .input_axis_tready(a_tready), .input_axis_tdata(in_data),
        .output_axis_tvalid(a_tvalid), .output_axis_tready(out_ready), .output_axis_tdata(a_tdata),
        .clear_stats(clear), .overflow_sticky(a_sticky), .overflow_count(a_oc),
        .beat_count(a_bc), .first_overflow_index(a_first)
    );

    overflow_flag_decoder #(.DATA_WIDTH(128), .FLAG_BIT(31), .CNT_WIDTH(4)) dut_b (
        .aclk(aclk), .areset(areset),
        .input_axis_tvalid(in_valid), .input_axis_tready(b_tready), .input_axis_tdata(in_data),
        .output_axis_tvalid(b_tvalid), .output_axis_tready(out_ready), .output_axis_tdata(b_tdata),
        .clear_stats(clear), .overflow_sticky(b_sticky), .overflow_count(b_oc),
        .beat_count(b_bc), .first_overflow_index(b_first)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;
    int b_pops = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Behavioural model: stored beats as a queue, statistics as plain integers.
    logic [127:0] m_q[$];
    longint       m_bc, m_oc, m_first;
    bit           m_sticky;

    function automatic longint satw(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge aclk) begin
        bit acc, pp;
        if (areset) begin
            m_q.delete();
            m_bc = 0; m_oc = 0; m_first = 0; m_sticky = 0;
        end else begin
            acc = in_valid && (m_q.size() < 2);
            pp  = (m_q.size() > 0) && out_ready;
            if (clear) begin
                m_bc = 0; m_oc = 0; m_first = 0; m_sticky = 0;
            end
            if (acc) begin
                if (in_data[31]) begin
                    if (!m_sticky) m_first = m_bc;
                    m_oc++;
                    m_sticky = 1;
                end
                m_bc++;
            end
            if (pp) void'(m_q.pop_front());
            if (acc) m_q.push_back(in_data & ~(128'h1 << 31));
        end
    end

    // Compare both instances against the model on every falling edge.
    always @(negedge aclk) begin
        if (cmp_en) begin
            chk("a_tready", a_tready, m_q.size() < 2);
            chk("b_tready", b_tready, m_q.size() < 2);
            chk("a_tvalid", a_tvalid, m_q.size() > 0);
            chk("b_tvalid", b_tvalid, m_q.size() > 0);
            if (m_q.size() > 0) begin
                chk("a_tdata", a_tdata, m_q[0]);
                chk("b_tdata", b_tdata, m_q[0]);
            end
            chk("a_beat_count", a_bc, satw(m_bc, 32));
            chk("b_beat_count", b_bc, satw(m_bc, 4));
            chk("a_overflow_count", a_oc, satw(m_oc, 32));
            chk("b_overflow_count", b_oc, satw(m_oc, 4));
            chk("a_sticky", a_sticky, m_sticky);
            chk("b_sticky", b_sticky, m_sticky);
            chk("a_first_index", a_first, satw(m_first, 32));
            chk("b_first_index", b_first, satw(m_first, 4));
            if (b_tvalid && out_ready && !areset) b_pops++;
        end
    end

    task automatic step(input logic v, input logic [127:0] d, input logic r, input logic c);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        clear     = c;
        @(posedge aclk);
        #1;
    endtask

    bit           will;
    int           sent;
    int           p0;
    logic [127:0] d[5];

    initial begin
        // Reset state
        step(0, '0, 0, 0);
        step(0, '0, 0, 0);
        areset = 1'b0;
        cmp_en = 1'b1;
        chk("rst_tready", a_tready, 1);
        chk("rst_tvalid", a_tvalid, 0);
        chk("rst_tdata", a_tdata, 0);
        chk("rst_beat_count", a_bc, 0);
        chk("rst_overflow_count", a_oc, 0);
        chk("rst_sticky", a_sticky, 0);
        chk("rst_first_index", a_first, 0);

        // 1. Streaming, four unflagged beats
        for (int i = 0; i < 4; i++) begin
            step(1, 128'(i) * 128'h1_0000_0001, 1, 0);
            if (i == 1) chk("t1_second_out", a_tdata, 128'h1_0000_0001);
        end
        step(0, '0, 1, 0);
        chk("t1_beat_count", a_bc, 4);
        chk("t1_overflow_count", a_oc, 0);
        chk("t1_sticky", a_sticky, 0);
        chk("t1_drained", a_tvalid, 0);

        // 2. Flag strip on the third beat
        step(0, '0, 1, 1);
        step(1, 128'h5, 1, 0);
        step(1, 128'h6, 1, 0);
        step(1, {128{1'b1}}, 1, 0);
        chk("t2_stripped", a_tdata, {{96{1'b1}}, 32'h7FFF_FFFF});
        chk("t2_overflow_count", a_oc, 1);
        chk("t2_sticky", a_sticky, 1);
        chk("t2_first_index", a_first, 2);
        step(0, '0, 1, 0);

        // 3. Backpressure: only two accepted while downstream stalls
        for (int i = 0; i < 5; i++) d[i] = 128'hA0 + 128'(i);
        sent = 0;
        for (int c = 0; c < 4; c++) begin
            will = a_tready;
            step(1, d[sent], 0, 0);
            if (will) begin
                sent++;
                if (sent == 2) chk("t3_tready_after_2nd", a_tready, 0);
            end
        end
        chk("t3_accepted_stalled", sent, 2);
        for (int c = 0; c < 20 && sent < 5; c++) begin
            will = a_tready;
            step(1, d[sent], 1, 0);
            if (will) sent++;
        end
        chk("t3_all_sent", sent, 5);
        step(0, '0, 1, 0);
        step(0, '0, 1, 0);
        step(0, '0, 1, 0);

        // 4. Clear in the same cycle as a flagged accept
        step(0, '0, 1, 1);
        for (int i = 0; i < 10; i++)
            step(1, (i == 4) ? 128'h8000_0004 : 128'(i), 1, 0);
        chk("t4_pre_beat_count", a_bc, 10);
        chk("t4_pre_first_index", a_first, 4);
        step(1, 128'h8000_BEEF, 1, 1);
        chk("t4_beat_count", a_bc, 1);
        chk("t4_overflow_count", a_oc, 1);
        chk("t4_first_index", a_first, 0);
        chk("t4_sticky", a_sticky, 1);
        step(0, '0, 1, 0);

        // 5. Saturation of the 4-bit counters over 20 flagged beats
        step(0, '0, 1, 1);
        p0 = b_pops;
        for (int i = 0; i < 20; i++)
            step(1, 128'h8000_0000 | (128'(i) << 40), 1, 0);
        step(0, '0, 1, 0);
        step(0, '0, 1, 0);
        chk("t5_b_beat_count", b_bc, 15);
        chk("t5_b_overflow_count", b_oc, 15);
        chk("t5_b_sticky", b_sticky, 1);
        chk("t5_b_first_index", b_first, 0);
        chk("t5_a_beat_count", a_bc, 20);
        chk("t5_b_forwarded", b_pops - p0, 20);

        // 6. Reset with a full buffer
        step(1, 128'h11, 0, 0);
        step(1, 128'h22, 0, 0);
        chk("t6_full_tready", a_tready, 0);
        chk("t6_full_tvalid", a_tvalid, 1);
        areset = 1'b1;
        step(0, '0, 0, 0);
        areset = 1'b0;
        chk("t6_tvalid", a_tvalid, 0);
        chk("t6_tready", a_tready, 1);
        chk("t6_beat_count", a_bc, 0);
        chk("t6_overflow_count", a_oc, 0);
        chk("t6_sticky", a_sticky, 0);
        chk("t6_first_index", a_first, 0);
        chk("t6_b_beat_count", b_bc, 0);
        chk("t6_b_tvalid", b_tvalid, 0);
        step(0, '0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
